// File: rtl/serial_tx.sv
`default_nettype none
// ============================================================================
// Module      : serial_tx
// Description : 8-bit parallel-to-serial transmitter, start/data/parity/stop
//               frame, LSB first, valid/ready input handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_tx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY       = 0
) (
    input  logic       C,
    input  logic       R_N,
    input  logic [7:0] D,
    input  logic       V,
    output logic       RDY,
    output logic       TXD,
    output logic       BUSY
);

    localparam logic [2:0] c_st_idle  = 3'd0;
    localparam logic [2:0] c_st_start = 3'd1;
    localparam logic [2:0] c_st_data  = 3'd2;
    localparam logic [2:0] c_st_par   = 3'd3;
    localparam logic [2:0] c_st_stop  = 3'd4;

    localparam logic [7:0] c_baud_last = 8'(CLKS_PER_BIT - 1);
    localparam logic       c_has_par   = (PARITY != 0);
    localparam logic       c_par_odd   = (PARITY == 2);

    logic [2:0] r_state;
    logic [7:0] r_baud;
    logic [2:0] r_bit;
    logic [7:0] r_shift;
    logic       r_par;
    logic       r_txd;
    logic       r_rdy;
    logic       r_busy;

    logic w_bit_end;
    logic w_par_next;

    assign w_bit_end  = (r_baud == c_baud_last);
    assign w_par_next = r_par ^ r_shift[0];

    // TXD is loaded with the value of the bit about to start, so the line
    // changes exactly on the state/bit boundary.
    always_ff @(posedge C or negedge R_N) begin
        if (!R_N) begin
            r_state <= c_st_idle;
            r_baud  <= 8'd0;
            r_bit   <= 3'd0;
            r_shift <= 8'd0;
            r_par   <= 1'b0;
            r_txd   <= 1'b1;
            r_rdy   <= 1'b1;
            r_busy  <= 1'b0;
        end else begin
            if (r_state != c_st_idle) begin
                r_baud <= w_bit_end ? 8'd0 : r_baud + 8'd1;
            end
            case (r_state)
                c_st_idle: begin
                    if (V) begin
                        r_shift <= D;
                        r_par   <= 1'b0;
                        r_baud  <= 8'd0;
                        r_bit   <= 3'd0;
                        r_txd   <= 1'b0;
                        r_rdy   <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= c_st_start;
                    end
                end
                c_st_start: begin
                    if (w_bit_end) begin
                        r_bit   <= 3'd0;
                        r_txd   <= r_shift[0];
                        r_state <= c_st_data;
                    end
                end
                c_st_data: begin
                    if (w_bit_end) begin
                        r_shift <= r_shift >> 1;
                        r_par   <= w_par_next;
                        r_bit   <= r_bit + 3'd1;
                        if (r_bit == 3'd7) begin
                            if (c_has_par) begin
                                r_txd   <= w_par_next ^ c_par_odd;
                                r_state <= c_st_par;
                            end else begin
                                r_txd   <= 1'b1;
                                r_state <= c_st_stop;
                            end
                        end else begin
                            r_txd <= r_shift[1];
                        end
                    end
                end
                c_st_par: begin
                    if (w_bit_end) begin
                        r_txd   <= 1'b1;
                        r_state <= c_st_stop;
                    end
                end
                c_st_stop: begin
                    if (w_bit_end) begin
                        r_txd   <= 1'b1;
                        r_rdy   <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= c_st_idle;
                    end
                end
                default: begin
                    r_txd   <= 1'b1;
                    r_rdy   <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

    assign RDY  = r_rdy;
    assign TXD  = r_txd;
    assign BUSY = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_serial_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_tx
// Description : Scoreboard bench for serial_tx: per-cycle line model for four
//               parameter sets plus a behavioural loopback receiver.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_tx;

    logic       clk    = 1'b0;
    logic       clk_en = 1'b0;
    logic       rst_n  = 1'b1;
    logic [3:0] v      = 4'h0;
    logic [7:0] d [4];
    wire  [3:0] rdy;
    wire  [3:0] txd;
    wire  [3:0] busy;

    int checks   = 0;
    int errors   = 0;
    int rx_count = 0;

    // Expected {txd, rdy, busy} per cycle while a frame is in flight.
    logic [2:0] q [4][$];
    logic [3:0] m_rdy = 4'hF;
    logic [7:0] sent [$];

    serial_tx #(.CLKS_PER_BIT(4),  .PARITY(0)) u0 (.C(clk), .R_N(rst_n), .D(d[0]), .V(v[0]),
                                                   .RDY(rdy[0]), .TXD(txd[0]), .BUSY(busy[0]));
    serial_tx #(.CLKS_PER_BIT(4),  .PARITY(1)) u1 (.C(clk), .R_N(rst_n), .D(d[1]), .V(v[1]),
                                                   .RDY(rdy[1]), .TXD(txd[1]), .BUSY(busy[1]));
    serial_tx #(.CLKS_PER_BIT(4),  .PARITY(2)) u2 (.C(clk), .R_N(rst_n), .D(d[2]), .V(v[2]),
                                                   .RDY(rdy[2]), .TXD(txd[2]), .BUSY(busy[2]));
    serial_tx #(.CLKS_PER_BIT(16), .PARITY(1)) u3 (.C(clk), .R_N(rst_n), .D(d[3]), .V(v[3]),
                                                   .RDY(rdy[3]), .TXD(txd[3]), .BUSY(busy[3]));

    initial begin
        wait (clk_en);
        forever #5 clk = ~clk;
    end

    function automatic int cpb_of(input int i);
        return (i == 3) ? 16 : 4;
    endfunction

    function automatic int parity_of(input int i);
        return (i == 0) ? 0 : (i == 2) ? 2 : 1;
    endfunction

    // Frame as a list of line levels, each held for one bit period.
    function automatic void push_frame(input int i, input logic [7:0] w);
        logic bits [$];
        bits.push_back(1'b0);
        for (int b = 0; b < 8; b++) bits.push_back(w[b]);
        if (parity_of(i) == 1) bits.push_back(^w);
        if (parity_of(i) == 2) bits.push_back(~^w);
        bits.push_back(1'b1);
        foreach (bits[k])
            for (int c = 0; c < cpb_of(i); c++) q[i].push_back({bits[k], 1'b0, 1'b1});
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, got, exp);
        end
    endtask

    // Model: accept on a rising edge where V is high and the model is ready.
    always @(posedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < 4; i++) begin
                if (v[i] && m_rdy[i]) begin
                    push_frame(i, d[i]);
                    if (i == 3) sent.push_back(d[i]);
                end
            end
        end
    end

    // Monitor: every cycle compare the line and flags with the model.
    always @(negedge clk) begin
        logic [2:0] e;
        logic [2:0] got;
        if (rst_n) begin
            for (int i = 0; i < 4; i++) begin
                e = (q[i].size() > 0) ? q[i].pop_front() : 3'b110;
                m_rdy[i] = e[1];
                got = {txd[i], rdy[i], busy[i]};
                checks++;
                if (got !== e) begin
                    errors++;
                    $display("FAIL line_u%0d t=%0t: txd/rdy/busy got %b want %b", i, $time, got, e);
                end
            end
        end
    end

    // Loopback receiver on u3: mid-bit sampling, even parity.
    initial begin
        logic [7:0] w;
        logic       p;
        forever begin
            @(negedge clk);
            if (rst_n && txd[3] === 1'b0) begin
                repeat (7) @(negedge clk);
                check("lb_start", 32'(txd[3]), 32'd0);
                for (int b = 0; b < 8; b++) begin
                    repeat (16) @(negedge clk);
                    w[b] = txd[3];
                end
                repeat (16) @(negedge clk);
                p = txd[3];
                check("lb_parity", 32'(p), 32'(^w));
                repeat (16) @(negedge clk);
                check("lb_stop", 32'(txd[3]), 32'd1);
                if (sent.size() > 0) check("lb_word", 32'(w), 32'(sent.pop_front()));
                else check("lb_unexpected_word", 32'(w), 32'hFFFF_FFFF);
                rx_count++;
            end
        end
    end

    task automatic send(input int i, input logic [7:0] w, input bit hold);
        int n = 0;
        d[i] = w;
        v[i] = 1'b1;
        forever begin
            @(posedge clk);
            if (m_rdy[i]) break;
            n++;
            if (n > 1000) begin
                checks++;
                errors++;
                $display("FAIL send_timeout_u%0d: got no acceptance want acceptance", i);
                break;
            end
        end
        #1;
        if (!hold) v[i] = 1'b0;
        d[i] = 8'($urandom);
    endtask

    task automatic wait_idle(input int i);
        int n = 0;
        while (!(q[i].size() == 0 && m_rdy[i]) && n < 2000) begin
            @(posedge clk);
            n++;
        end
        if (n >= 2000) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout_u%0d: got busy want idle", i);
        end
        #1;
    endtask

    task automatic frame_len(input int i, input int exp_len, input int par_cyc, input logic par_exp);
        int n = 0;
        while (n < 200) begin
            @(negedge clk);
            if (rdy[i]) break;
            n++;
            if (n == par_cyc) check($sformatf("parity_bit_u%0d", i), 32'(txd[i]), 32'(par_exp));
        end
        check($sformatf("rdy_low_len_u%0d", i), 32'(n), 32'(exp_len));
    endtask

    initial begin
        int n;
        for (int i = 0; i < 4; i++) d[i] = 8'h00;

        // Reset with no clock running.
        #1 rst_n = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("reset_txd_u%0d", i),  32'(txd[i]),  32'd1);
            check($sformatf("reset_rdy_u%0d", i),  32'(rdy[i]),  32'd1);
            check($sformatf("reset_busy_u%0d", i), 32'(busy[i]), 32'd0);
        end
        clk_en = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        send(0, 8'hA5, 1'b0);
        frame_len(0, 40, 0, 1'b0);
        wait_idle(0);

        send(1, 8'h07, 1'b0);
        frame_len(1, 44, 38, 1'b1);
        send(2, 8'h07, 1'b0);
        frame_len(2, 44, 38, 1'b0);
        wait_idle(1);
        wait_idle(2);

        // Back-to-back with V held; D moves to 8'hFF during frame 1.
        send(0, 8'h00, 1'b1);
        send(0, 8'hFF, 1'b0);
        wait_idle(0);

        for (int k = 0; k < 30; k++) begin
            send($urandom_range(0, 2), 8'($urandom), 1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 6)) @(posedge clk);
            #1;
        end
        v[2:0] = 3'b000;
        for (int i = 0; i < 3; i++) wait_idle(i);

        // Reset pulse during data bit 3 of 8'h55 (a 0 on the line).
        send(0, 8'h55, 1'b0);
        repeat (17) @(posedge clk);
        #2 rst_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            q[i].delete();
            m_rdy[i] = 1'b1;
        end
        #1;
        check("midreset_txd",  32'(txd[0]),  32'd1);
        check("midreset_rdy",  32'(rdy[0]),  32'd1);
        check("midreset_busy", 32'(busy[0]), 32'd0);
        #1 rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        send(0, 8'h55, 1'b0);
        wait_idle(0);

        // Loopback: 256 words with random V gaps.
        for (int w = 0; w < 256; w++) begin
            send(3, 8'(w), 1'b0);
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
        end
        wait_idle(3);
        n = 0;
        while (rx_count < 256 && n < 2000) begin
            @(posedge clk);
            n++;
        end
        check("lb_count", 32'(rx_count), 32'd256);
        check("lb_leftover", 32'(sent.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
